// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// values, ALU operation codes and datapath mux selects.
package mcpu_pkg;

    typedef enum logic [4:0] {
        S_IF     = 5'd0,
        S_ID     = 5'd1,
        S_EX_R   = 5'd2,
        S_WB_R   = 5'd3,
        S_EX_I   = 5'd4,
        S_WB_I   = 5'd5,
        S_EX_MA  = 5'd6,
        S_MEM_RD = 5'd7,
        S_WB_LW  = 5'd8,
        S_MEM_WR = 5'd9,
        S_BR     = 5'd10,
        S_JMP    = 5'd11,
        S_JAL    = 5'd12,
        S_JR     = 5'd13,
        S_JALR   = 5'd14,
        S_WB_LUI = 5'd15,
        S_ERET   = 5'd16,
        S_INT    = 5'd17
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ERET  = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] PCS_ALU    = 3'b000;
    localparam logic [2:0] PCS_ALUOUT = 3'b001;
    localparam logic [2:0] PCS_JUMP   = 3'b010;
    localparam logic [2:0] PCS_RS     = 3'b011;
    localparam logic [2:0] PCS_EPC    = 3'b100;
    localparam logic [2:0] PCS_VECTOR = 3'b101;

    localparam logic [1:0] DTR_ALUOUT = 2'b00;
    localparam logic [1:0] DTR_MDR    = 2'b01;
    localparam logic [1:0] DTR_LUI    = 2'b10;
    localparam logic [1:0] DTR_PC     = 2'b11;

    // Returns {valid, alu_code} for an R-type ALU funct field.
    function automatic logic [3:0] fun_alu(input logic [5:0] fun);
        case (fun)
            6'b100000: fun_alu = {1'b1, ALU_ADD};
            6'b100010: fun_alu = {1'b1, ALU_SUB};
            6'b100100: fun_alu = {1'b1, ALU_AND};
            6'b100101: fun_alu = {1'b1, ALU_OR};
            6'b100110: fun_alu = {1'b1, ALU_XOR};
            6'b100111: fun_alu = {1'b1, ALU_NOR};
            6'b000010: fun_alu = {1'b1, ALU_SRL};
            6'b101010: fun_alu = {1'b1, ALU_SLT};
            default:   fun_alu = {1'b0, ALU_AND};
        endcase
    endfunction

    // ALU code for the immediate-arithmetic opcodes.
    function automatic logic [2:0] op_alu(input logic [5:0] op);
        case (op)
            OP_ADDI: op_alu = ALU_ADD;
            OP_ANDI: op_alu = ALU_AND;
            OP_ORI:  op_alu = ALU_OR;
            OP_XORI: op_alu = ALU_XOR;
            OP_SLTI: op_alu = ALU_SLT;
            default: op_alu = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_ctrl_int_arb.sv
// Interrupt pending register: rising-edge capture per line, fixed priority
// (lowest index wins), one-hot acknowledge while the controller is granting.
module int_pending_arb #(
    parameter int N_INT    = 4,
    parameter int INT_ID_W = (N_INT > 1) ? $clog2(N_INT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INT-1:0]    int_req_i,
    input  logic                grant_i,
    output logic                any_pending_o,
    output logic [INT_ID_W-1:0] int_id_o,
    output logic [N_INT-1:0]    int_ack_o
);

    logic [N_INT-1:0] hist_q, pending_q, pending_d, rise_s;
    logic             found_s;

    // Lowest-index pending source, acknowledge and next pending state.
    always_comb begin
        int_id_o = '0;
        found_s  = 1'b0;
        for (int i = 0; i < N_INT; i++) begin
            if (pending_q[i] && !found_s) begin
                int_id_o = INT_ID_W'(i);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
        any_pending_o = |pending_q;
        int_ack_o     = (grant_i && found_s) ? (N_INT'(1) << int_id_o) : '0;
        rise_s        = int_req_i & ~hist_q;
        // A fresh edge on the bit being acknowledged keeps it pending.
        pending_d     = (pending_q & ~int_ack_o) | rise_s;
    end

    // Request history and pending bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            pending_q <= '0;
        end else begin
            hist_q    <= int_req_i;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/mcpu_ctrl_int.sv
// Multi-cycle MIPS control FSM with memory stall and vectored interrupts taken
// only at instruction boundaries.
module mcpu_ctrl_int
    import mcpu_pkg::*;
#(
    parameter int N_INT      = 4,
    parameter int INT_ID_W   = (N_INT > 1) ? $clog2(N_INT) : 1,
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            OPcode,
    input  logic [5:0]            Fun,
    input  logic                  zero,
    input  logic                  MIO_ready,
    input  logic [N_INT-1:0]      int_req,
    input  logic                  int_en,
    output logic                  IorD,
    output logic                  IRWrite,
    output logic                  mem_r,
    output logic                  mem_w,
    output logic                  CPU_MIO,
    output logic                  RegDst,
    output logic                  Jal,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrc_B,
    output logic [ALU_CTRL_W-1:0] ALU_Control,
    output logic [1:0]            DatatoReg,
    output logic                  RegWrite,
    output logic                  PCWrite,
    output logic [2:0]            PCSource,
    output logic                  epc_we,
    output logic [INT_ID_W-1:0]   int_id,
    output logic [N_INT-1:0]      int_ack,
    output logic                  in_isr,
    output logic                  illegal,
    output logic [4:0]            state
);

    state_e     state_q, state_d, bound_s;
    logic       in_isr_q, in_isr_d;
    logic       any_pending_s;
    logic [2:0] alu_s;
    logic [3:0] fun_dec_s;

    int_pending_arb #(.N_INT(N_INT), .INT_ID_W(INT_ID_W)) u_arb (
        .clk           (clk),
        .rst           (rst),
        .int_req_i     (int_req),
        .grant_i       ((state_q == S_INT) && !rst),
        .any_pending_o (any_pending_s),
        .int_id_o      (int_id),
        .int_ack_o     (int_ack)
    );

    assign in_isr      = in_isr_q;
    assign state       = rst ? 5'd0 : state_q;
    assign ALU_Control = ALU_CTRL_W'(alu_s);
    assign fun_dec_s   = fun_alu(Fun);

    // Next state, ISR flag and Moore datapath controls; everything idles in reset.
    always_comb begin
        state_d   = state_q;
        in_isr_d  = in_isr_q;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        CPU_MIO   = 1'b0;
        RegDst    = 1'b0;
        Jal       = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrc_B  = 2'b00;
        alu_s     = ALU_AND;
        DatatoReg = DTR_ALUOUT;
        RegWrite  = 1'b0;
        PCWrite   = 1'b0;
        PCSource  = PCS_ALU;
        epc_we    = 1'b0;
        illegal   = 1'b0;
        bound_s   = (int_en && !in_isr_q && any_pending_s) ? S_INT : S_IF;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    mem_r   = 1'b1;
                    CPU_MIO = 1'b1;
                    if (MIO_ready) begin
                        IRWrite  = 1'b1;
                        PCWrite  = 1'b1;
                        ALUSrc_B = 2'b01;
                        alu_s    = ALU_ADD;
                        state_d  = S_ID;
                    end else begin
                        state_d  = S_IF;
                    end
                end
                S_ID: begin
                    ALUSrc_B = 2'b11;
                    alu_s    = ALU_ADD;
                    case (OPcode)
                        OP_RTYPE: begin
                            if (Fun == FN_JR) begin
                                state_d = S_JR;
                            end else if (Fun == FN_JALR) begin
                                state_d = S_JALR;
                            end else if (fun_dec_s[3]) begin
                                state_d = S_EX_R;
                            end else begin
                                illegal = 1'b1;
                                state_d = bound_s;
                            end
                        end
                        OP_LW, OP_SW:                              state_d = S_EX_MA;
                        OP_BEQ, OP_BNE:                            state_d = S_BR;
                        OP_J:                                      state_d = S_JMP;
                        OP_JAL:                                    state_d = S_JAL;
                        OP_LUI:                                    state_d = S_WB_LUI;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_EX_I;
                        OP_ERET:                                   state_d = S_ERET;
                        default: begin
                            illegal = 1'b1;
                            state_d = bound_s;
                        end
                    endcase
                end
                S_EX_R: begin
                    ALUSrcA = 1'b1;
                    alu_s   = fun_dec_s[2:0];
                    state_d = S_WB_R;
                end
                S_WB_R: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    state_d  = bound_s;
                end
                S_EX_I: begin
                    ALUSrcA  = 1'b1;
                    ALUSrc_B = 2'b10;
                    alu_s    = op_alu(OPcode);
                    state_d  = S_WB_I;
                end
                S_WB_I: begin
                    RegWrite = 1'b1;
                    state_d  = bound_s;
                end
                S_EX_MA: begin
                    ALUSrcA  = 1'b1;
                    ALUSrc_B = 2'b10;
                    alu_s    = ALU_ADD;
                    state_d  = (OPcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_r   = 1'b1;
                    CPU_MIO = 1'b1;
                    IorD    = 1'b1;
                    state_d = MIO_ready ? S_WB_LW : S_MEM_RD;
                end
                S_WB_LW: begin
                    RegWrite  = 1'b1;
                    DatatoReg = DTR_MDR;
                    state_d   = bound_s;
                end
                S_MEM_WR: begin
                    mem_w   = 1'b1;
                    CPU_MIO = 1'b1;
                    IorD    = 1'b1;
                    state_d = MIO_ready ? bound_s : S_MEM_WR;
                end
                S_BR: begin
                    ALUSrcA  = 1'b1;
                    alu_s    = ALU_SUB;
                    PCSource = PCS_ALUOUT;
                    // OPcode[0] separates bne (000101) from beq (000100).
                    PCWrite  = zero ^ OPcode[0];
                    state_d  = bound_s;
                end
                S_JMP, S_JAL: begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_JUMP;
                    if (state_q == S_JAL) begin
                        RegWrite  = 1'b1;
                        Jal       = 1'b1;
                        DatatoReg = DTR_PC;
                    end else begin
                        RegWrite  = 1'b0;
                    end
                    state_d  = bound_s;
                end
                S_JR, S_JALR: begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_RS;
                    if (state_q == S_JALR) begin
                        RegWrite  = 1'b1;
                        RegDst    = 1'b1;
                        DatatoReg = DTR_PC;
                    end else begin
                        RegWrite  = 1'b0;
                    end
                    state_d  = bound_s;
                end
                S_WB_LUI: begin
                    RegWrite  = 1'b1;
                    DatatoReg = DTR_LUI;
                    state_d   = bound_s;
                end
                S_ERET: begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_EPC;
                    in_isr_d = 1'b0;
                    // Leaving the handler, so another pending source may enter at once.
                    state_d  = (int_en && any_pending_s) ? S_INT : S_IF;
                end
                S_INT: begin
                    epc_we   = 1'b1;
                    PCWrite  = 1'b1;
                    PCSource = PCS_VECTOR;
                    in_isr_d = 1'b1;
                    state_d  = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end else begin
            state_d  = S_IF;
            in_isr_d = 1'b0;
        end
    end

    // State and handler-active registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IF;
            in_isr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_isr_q <= in_isr_d;
        end
    end

endmodule
